// File: rtl/twos_com_serial.sv
// Digit-serial two's-complement unit: pass / negate / abs / -abs, DIGIT bits per cycle, LSB first.
// Optional build macro TWOS_COM_SATURATE_EN clamps overflowed results to the max positive value.
module twos_com_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_NUM,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_NUM,
  output logic             OVF
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef TWOS_COM_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("twos_com_serial: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             neg;

  logic             accept_c;
  logic             last_c;
  logic             neg_c;
  logic             ovf_c;
  logic [DIGIT-1:0] digit_c;
  logic [DIGIT:0]   sum_c;
  logic [DIGIT-1:0] dnew_c;
  logic [WIDTH-1:0] shifted_c;

  // Operand decode and the per-digit invert-plus-carry step
  always_comb begin
    accept_c  = (state == IDLE) && IN_VALID;
    last_c    = (state == BUSY) && (cnt == CNT_W'(N - 1));
    neg_c     = (MODE == 2'b01)
              | ((MODE == 2'b10) &  IN_NUM[WIDTH-1])
              | ((MODE == 2'b11) & ~IN_NUM[WIDTH-1]);
    ovf_c     = neg_c && (IN_NUM == MIN_NEG);
    digit_c   = op[DIGIT-1:0];
    sum_c     = {1'b0, ~digit_c} + {{DIGIT{1'b0}}, carry};
    dnew_c    = neg ? sum_c[DIGIT-1:0] : digit_c;
    shifted_c = (OUT_NUM >> DIGIT) | (WIDTH'(dnew_c) << (WIDTH - DIGIT));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IN_VALID)  state_nxt = BUSY;
      BUSY:    if (last_c)    state_nxt = DONE;
      DONE:    if (OUT_READY) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered decodes of the next state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
    end else begin
      state     <= state_nxt;
      IN_READY  <= (state_nxt == IDLE);
      OUT_VALID <= (state_nxt == DONE);
    end
  end

  // Result shifts in from the top so it is complete, LSB-aligned, after N digits
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op      <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      neg     <= 1'b0;
      OUT_NUM <= '0;
      OVF     <= 1'b0;
    end else if (accept_c) begin
      op    <= IN_NUM;
      neg   <= neg_c;
      carry <= neg_c;
      cnt   <= '0;
      OVF   <= ovf_c;
    end else if (state == BUSY) begin
      op    <= op >> DIGIT;
      carry <= neg & sum_c[DIGIT];
      cnt   <= last_c ? '0 : cnt + CNT_W'(1);
`ifdef TWOS_COM_SATURATE_EN
      OUT_NUM <= (last_c && OVF) ? MAX_POS : shifted_c;
`else
      OUT_NUM <= shifted_c;
`endif
    end
  end

endmodule

// File: tb/tb_twos_com_serial.sv
// Bench for twos_com_serial: 8-bit/1-digit and 16-bit/4-digit instances against an integer reference model.
module tb_twos_com_serial;

  logic        clk;
  logic        rst_n;
  logic        iv8, ir8, ov8, rdy8, ovf8;
  logic [7:0]  num8, on8;
  logic [1:0]  mode8;
  logic        iv16, ir16, ov16, rdy16, ovf16;
  logic [15:0] num16, on16;
  logic [1:0]  mode16;

  int checks;
  int failures;

  twos_com_serial #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv8), .IN_READY(ir8), .IN_NUM(num8),
    .MODE(mode8), .OUT_VALID(ov8), .OUT_READY(rdy8), .OUT_NUM(on8), .OVF(ovf8)
  );

  twos_com_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv16), .IN_READY(ir16), .IN_NUM(num16),
    .MODE(mode16), .OUT_VALID(ov16), .OUT_READY(rdy16), .OUT_NUM(on16), .OVF(ovf16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: signed integer arithmetic, returns {ovf, result}
  function automatic logic [16:0] model(input logic [15:0] x, input int w, input logic [1:0] m);
    longint v, r, maxp;
    logic   o;
    v = longint'(x);
    if (x[w-1]) v = v - (longint'(1) << w);
    case (m)
      2'b00:   r = v;
      2'b01:   r = -v;
      2'b10:   r = (v < 0) ? -v : v;
      default: r = (v < 0) ? v : -v;
    endcase
    maxp = (longint'(1) << (w - 1)) - 1;
    o = (r > maxp);
`ifdef TWOS_COM_SATURATE_EN
    if (o) r = maxp;
`endif
    return {o, 16'(r & ((longint'(1) << w) - 1))};
  endfunction

  task automatic run_op8(input logic [7:0] x, input logic [1:0] m,
                         output logic [7:0] r, output logic o, output int lat);
    int guard;
    guard = 0;
    while (!ir8 && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin
      checks++; failures++;
      $display("FAIL op8_ready_timeout in_ready=%b required=1", ir8);
    end
    iv8 = 1'b1; num8 = x; mode8 = m;
    @(posedge clk); #1;
    iv8 = 1'b0; num8 = 8'($urandom); mode8 = 2'($urandom);
    lat = 0;
    while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
    r = on8; o = ovf8;
  endtask

  task automatic run_op16(input logic [15:0] x, input logic [1:0] m,
                          output logic [15:0] r, output logic o, output int lat);
    int guard;
    guard = 0;
    while (!ir16 && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin
      checks++; failures++;
      $display("FAIL op16_ready_timeout in_ready=%b required=1", ir16);
    end
    iv16 = 1'b1; num16 = x; mode16 = m;
    @(posedge clk); #1;
    iv16 = 1'b0; num16 = 16'($urandom); mode16 = 2'($urandom);
    lat = 0;
    while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
    r = on16; o = ovf16;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || on8 !== 8'h00 || ovf8 !== 1'b0) begin
      failures++;
      $display("FAIL reset8 got ir=%b ov=%b num=%h ovf=%b required 1 0 00 0", ir8, ov8, on8, ovf8);
    end
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || on16 !== 16'h0000 || ovf16 !== 1'b0) begin
      failures++;
      $display("FAIL reset16 got ir=%b ov=%b num=%h ovf=%b required 1 0 0000 0", ir16, ov16, on16, ovf16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [7:0]  r8, e8;
    logic [15:0] r16;
    logic        o;
    int          lat;
    run_op8(8'h05, 2'b01, r8, o, lat);
    checks++;
    if (r8 !== 8'hFB || o !== 1'b0 || lat != 8) begin
      failures++;
      $display("FAIL vec_neg05 got %h/%b lat=%0d required fb/0 lat=8", r8, o, lat);
    end
`ifdef TWOS_COM_SATURATE_EN
    e8 = 8'h7F;
`else
    e8 = 8'h80;
`endif
    run_op8(8'h80, 2'b10, r8, o, lat);
    checks++;
    if (r8 !== e8 || o !== 1'b1) begin
      failures++;
      $display("FAIL vec_abs80 got %h/%b required %h/1", r8, o, e8);
    end
    run_op16(16'h0123, 2'b11, r16, o, lat);
    checks++;
    if (r16 !== 16'hFEDD || o !== 1'b0 || lat != 4) begin
      failures++;
      $display("FAIL vec_nabs0123 got %h/%b lat=%0d required fedd/0 lat=4", r16, o, lat);
    end
    run_op16(16'hFFFF, 2'b10, r16, o, lat);
    checks++;
    if (r16 !== 16'h0001 || o !== 1'b0) begin
      failures++;
      $display("FAIL vec_absffff got %h/%b required 0001/0", r16, o);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] r8;
    logic       o;
    int         lat;
    rdy8 = 1'b0;
    run_op8(8'h3C, 2'b01, r8, o, lat);
    checks++;
    if (r8 !== 8'hC4) begin
      failures++;
      $display("FAIL bp_result got %h required c4", r8);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (on8 !== 8'hC4 || ov8 !== 1'b1 || ir8 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got num=%h ov=%b ir=%b required c4 1 0", i, on8, ov8, ir8);
      end
    end
    rdy8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      failures++;
      $display("FAIL bp_release got ir=%b ov=%b required 1 0", ir8, ov8);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [7:0] r8;
    logic       o;
    int         lat;
    @(negedge clk);
    iv8 = 1'b1; num8 = 8'h5A; mode8 = 2'b00;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (on8 !== 8'h00 || ov8 !== 1'b0 || ovf8 !== 1'b0 || ir8 !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got num=%h ov=%b ovf=%b ir=%b required 00 0 0 1", on8, ov8, ovf8, ir8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op8(8'hA5, 2'b00, r8, o, lat);
    checks++;
    if (r8 !== 8'hA5 || o !== 1'b0 || lat != 8) begin
      failures++;
      $display("FAIL post_reset_op got %h/%b lat=%0d required a5/0 lat=8", r8, o, lat);
    end
  endtask

  task automatic test_sweep();
    logic [7:0]  r8;
    logic        o;
    int          lat;
    logic [16:0] e;
    for (int m = 0; m < 4; m++) begin
      for (int x = 0; x < 256; x++) begin
        e = model(16'(x), 8, 2'(m));
        run_op8(8'(x), 2'(m), r8, o, lat);
        checks++;
        if (r8 !== e[7:0] || o !== e[16] || lat != 8) begin
          failures++;
          $display("FAIL sweep x=%h m=%0d got %h/%b lat=%0d required %h/%b lat=8",
                   x[7:0], m, r8, o, lat, e[7:0], e[16]);
        end
      end
    end
  endtask

  task automatic test_random16();
    logic [15:0] x, r16;
    logic [1:0]  m;
    logic        o;
    int          lat, stall;
    logic [16:0] e;
    for (int k = 0; k < 150; k++) begin
      x = (k % 10 == 0) ? 16'h8000 : 16'($urandom);
      m = 2'($urandom);
      e = model(x, 16, m);
      stall = int'($urandom_range(0, 3));
      rdy16 = (stall == 0);
      run_op16(x, m, r16, o, lat);
      checks++;
      if (r16 !== e[15:0] || o !== e[16] || lat != 4) begin
        failures++;
        $display("FAIL rand16 x=%h m=%0d got %h/%b lat=%0d required %h/%b lat=4",
                 x, m, r16, o, lat, e[15:0], e[16]);
      end
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        checks++;
        if (on16 !== e[15:0] || ov16 !== 1'b1 || ir16 !== 1'b0) begin
          failures++;
          $display("FAIL rand16_hold got num=%h ov=%b ir=%b required %h 1 0", on16, ov16, ir16, e[15:0]);
        end
      end
      rdy16 = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] expq[$];
    logic [16:0] e;
    logic [7:0]  x;
    logic [1:0]  m;
    int          pushed, last_cyc, got;
    pushed = 0; last_cyc = -1; got = 0;
    rdy8 = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (ov8) begin
        e = expq.pop_front();
        checks++;
        if (on8 !== e[7:0] || ovf8 !== e[16]) begin
          failures++;
          $display("FAIL b2b_result got %h/%b required %h/%b", on8, ovf8, e[7:0], e[16]);
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 10) begin
            failures++;
            $display("FAIL b2b_spacing got %0d cycles required 10", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
      if (ir8 && pushed < 6) begin
        x = 8'($urandom); m = 2'($urandom);
        iv8 = 1'b1; num8 = x; mode8 = m;
        expq.push_back(model(16'(x), 8, m));
        pushed++;
      end else if (ir8) begin
        iv8 = 1'b0;
      end else begin
        num8 = 8'($urandom); mode8 = 2'($urandom);
      end
      if (pushed == 6 && expq.size() == 0) break;
    end
    iv8 = 1'b0;
    checks++;
    if (got != 6) begin
      failures++;
      $display("FAIL b2b_count got %0d results required 6", got);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1;
    iv8 = 1'b0; num8 = '0; mode8 = '0; rdy8 = 1'b1;
    iv16 = 1'b0; num16 = '0; mode16 = '0; rdy16 = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_busy();
    test_sweep();
    test_random16();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
